// File: rtl/pixel_compositor.sv
`default_nettype none
// ============================================================================
// Module   : pixel_compositor
// Purpose  : Overlays one colour-keyed sprite on a VGA background stream.
//            Two-stage pipeline. The sprite position is double-buffered and
//            only updated at the frame boundary, so a frame never shows a
//            torn sprite.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_compositor #(
    parameter int          SPR_W    = 32,
    parameter int          SPR_H    = 32,
    parameter logic [11:0] KEY      = 12'h0F0,
    parameter int          V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] bg_pixel,
    input  logic [11:0] spr_pixel,
    input  logic        pos_req,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    output logic [9:0]  spr_addr,
    output logic        pos_ack,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync_o,
    output logic        vsync_o
);

    // SPR_W is a power of two, so the row stride becomes a shift
    localparam int          c_SHIFT    = $clog2(SPR_W);
    localparam logic [10:0] c_SPR_W11  = 11'(SPR_W);
    localparam logic [10:0] c_SPR_H11  = 11'(SPR_H);
    localparam logic [9:0]  c_V_ACTIVE = 10'(V_ACTIVE);

    // Position registers: active copy used for hit testing, pending copy
    // waiting for the next frame boundary
    logic [9:0]  r_act_x;
    logic [9:0]  r_act_y;
    logic [9:0]  r_pend_x;
    logic [9:0]  r_pend_y;
    logic        r_pend_valid;

    // Pipeline registers
    logic        r_s1_valid;
    logic        r_s1_hit;
    logic        r_s1_hsync;
    logic        r_s1_vsync;
    logic [11:0] r_colour;
    logic        r_hsync_o;
    logic        r_vsync_o;

    logic        w_boundary;
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic        w_hit;
    logic [9:0]  w_dx;
    logic [9:0]  w_dy;
    logic [9:0]  w_addr_raw;
    logic [11:0] w_colour;

    assign w_boundary = (h_cnt == 10'd0) && (v_cnt == c_V_ACTIVE);

    // Sprite extents at 11 bits so a sprite near the right/bottom edge
    // clips instead of wrapping around to column/line 0
    assign w_x_end = {1'b0, r_act_x} + c_SPR_W11;
    assign w_y_end = {1'b0, r_act_y} + c_SPR_H11;

    assign w_hit = valid
                && (h_cnt >= r_act_x) && ({1'b0, h_cnt} < w_x_end)
                && (v_cnt >= r_act_y) && ({1'b0, v_cnt} < w_y_end);

    // Offset within the sprite; row-major ROM address, 0 outside the sprite
    assign w_dx       = h_cnt - r_act_x;
    assign w_dy       = v_cnt - r_act_y;
    assign w_addr_raw = (w_dy << c_SHIFT) + w_dx;
    assign spr_addr   = w_hit ? w_addr_raw : 10'd0;

    // Acknowledge is asserted during the very boundary cycle that applies it
    assign pos_ack = w_boundary && r_pend_valid;

    // Position double buffer: capture requests, swap at the frame boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_act_x      <= 10'd0;
            r_act_y      <= 10'd0;
            r_pend_x     <= 10'd0;
            r_pend_y     <= 10'd0;
            r_pend_valid <= 1'b0;
        end else begin
            if (w_boundary && r_pend_valid) begin
                r_act_x <= r_pend_x;
                r_act_y <= r_pend_y;
            end
            if (pos_req) begin
                // A coincident request stays pending for the next boundary
                r_pend_x     <= sprite_x;
                r_pend_y     <= sprite_y;
                r_pend_valid <= 1'b1;
            end else if (w_boundary) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Stage 1: register qualifiers alongside the ROM/BRAM read latency.
    // Syncs idle high so no spurious sync pulse follows reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_hit   <= 1'b0;
            r_s1_hsync <= 1'b1;
            r_s1_vsync <= 1'b1;
        end else begin
            r_s1_valid <= valid;
            r_s1_hit   <= w_hit;
            r_s1_hsync <= hsync;
            r_s1_vsync <= vsync;
        end
    end

    // Colour select: blank outside the visible area, key out transparent texels
    always_comb begin
        w_colour = bg_pixel;
        if (!r_s1_valid) begin
            w_colour = 12'h000;
        end else if (r_s1_hit && (spr_pixel != KEY)) begin
            w_colour = spr_pixel;
        end
    end

    // Stage 2: register final colour and syncs so they leave aligned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_colour  <= 12'h000;
            r_hsync_o <= 1'b1;
            r_vsync_o <= 1'b1;
        end else begin
            r_colour  <= w_colour;
            r_hsync_o <= r_s1_hsync;
            r_vsync_o <= r_s1_vsync;
        end
    end

    assign vga_r   = r_colour[11:8];
    assign vga_g   = r_colour[7:4];
    assign vga_b   = r_colour[3:0];
    assign hsync_o = r_hsync_o;
    assign vsync_o = r_vsync_o;

endmodule
`default_nettype wire

// File: tb/tb_pixel_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_compositor
// Purpose  : Directed self-checking bench for pixel_compositor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_compositor;

    logic        clk;
    logic        rst;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        valid;
    logic        hsync;
    logic        vsync;
    logic [11:0] bg_pixel;
    logic [11:0] spr_pixel;
    logic        pos_req;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
    logic [9:0]  spr_addr;
    logic        pos_ack;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        hsync_o;
    logic        vsync_o;

    int n_checks;
    int n_errors;

    pixel_compositor #(
        .SPR_W    (32),
        .SPR_H    (32),
        .KEY      (12'h0F0),
        .V_ACTIVE (480)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .valid     (valid),
        .hsync     (hsync),
        .vsync     (vsync),
        .bg_pixel  (bg_pixel),
        .spr_pixel (spr_pixel),
        .pos_req   (pos_req),
        .sprite_x  (sprite_x),
        .sprite_y  (sprite_y),
        .spr_addr  (spr_addr),
        .pos_ack   (pos_ack),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o)
    );

    // 25 MHz pixel clock
    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] rgb();
        return {vga_r, vga_g, vga_b};
    endfunction

    // One pixel-clock cycle of stimulus; returns with inputs settled mid-cycle
    task automatic tick(input logic [9:0] h, input logic [9:0] v,
                        input logic val, input logic hs, input logic vs);
        @(posedge clk);
        #2;
        h_cnt   = h;
        v_cnt   = v;
        valid   = val;
        hsync   = hs;
        vsync   = vs;
        pos_req = 1'b0;
        #2;
    endtask

    // Cycle carrying a position request (blanked pixel)
    task automatic tick_req(input logic [9:0] h, input logic [9:0] v,
                            input logic [9:0] x, input logic [9:0] y);
        @(posedge clk);
        #2;
        h_cnt    = h;
        v_cnt    = v;
        valid    = 1'b0;
        hsync    = 1'b1;
        vsync    = 1'b1;
        pos_req  = 1'b1;
        sprite_x = x;
        sprite_y = y;
        #2;
    endtask

    task automatic idle();
        tick(10'd700, 10'd500, 1'b0, 1'b1, 1'b1);
    endtask

    // Present one visible pixel, check address now and colour 2 cycles later
    task automatic probe(input string tag, input logic [9:0] h, input logic [9:0] v,
                         input logic [9:0] exp_addr, input logic [11:0] exp_rgb);
        tick(h, v, 1'b1, 1'b1, 1'b1);
        check({tag, "_addr"}, 32'(spr_addr), 32'(exp_addr));
        idle();
        idle();
        check({tag, "_rgb"}, 32'(rgb()), 32'(exp_rgb));
    endtask

    task automatic boundary(input string tag, input logic exp_ack);
        tick(10'd0, 10'd480, 1'b0, 1'b1, 1'b1);
        check({tag, "_ack"}, 32'(pos_ack), 32'(exp_ack));
        idle();
        check({tag, "_ack_low"}, 32'(pos_ack), 32'd0);
    endtask

    logic hs_pat [6];
    logic vs_pat [6];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        h_cnt     = 10'd700;
        v_cnt     = 10'd500;
        valid     = 1'b0;
        hsync     = 1'b1;
        vsync     = 1'b1;
        bg_pixel  = 12'hABC;
        spr_pixel = 12'hF00;
        pos_req   = 1'b0;
        sprite_x  = 10'd0;
        sprite_y  = 10'd0;
        hs_pat    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vs_pat    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #4;
        check("rst_rgb", 32'(rgb()), 32'h000);
        check("rst_hsync", 32'(hsync_o), 32'd1);
        check("rst_vsync", 32'(vsync_o), 32'd1);
        check("rst_ack", 32'(pos_ack), 32'd0);
        @(posedge clk);
        #10 rst = 1'b1;

        // Background only, latency of exactly 2 on colour and syncs
        for (int i = 0; i < 6; i++) begin
            tick(10'(200 + i), 10'd100, 1'b1, hs_pat[i], vs_pat[i]);
            if (i < 2) begin
                check("lat_rgb_early", 32'(rgb()), 32'h000);
            end else begin
                check("bg_rgb", 32'(rgb()), 32'hABC);
                check("lat_hsync", 32'(hsync_o), 32'(hs_pat[i-2]));
                check("lat_vsync", 32'(vsync_o), 32'(vs_pat[i-2]));
            end
        end

        // Move sprite to (100,50)
        bg_pixel = 12'h123;
        tick_req(10'd300, 10'd300, 10'd100, 10'd50);
        idle();
        check("no_early_ack", 32'(pos_ack), 32'd0);
        probe("old_pos", 10'd100, 10'd50, 10'd0, 12'h123);
        boundary("b1", 1'b1);
        probe("tl", 10'd100, 10'd50, 10'd0, 12'hF00);
        probe("br", 10'd131, 10'd81, 10'd1023, 12'hF00);
        probe("right_out", 10'd132, 10'd50, 10'd0, 12'h123);
        probe("left_out", 10'd99, 10'd50, 10'd0, 12'h123);
        probe("below_out", 10'd100, 10'd82, 10'd0, 12'h123);

        // Colour key
        spr_pixel = 12'h0F0;
        probe("key", 10'd110, 10'd60, 10'd330, 12'h123);
        spr_pixel = 12'hF00;
        probe("opaque", 10'd110, 10'd60, 10'd330, 12'hF00);
        // Blanked pixel in hit area
        tick(10'd110, 10'd60, 1'b0, 1'b1, 1'b1);
        check("blank_addr", 32'(spr_addr), 32'd0);
        idle();
        idle();
        check("blank_rgb", 32'(rgb()), 32'h000);

        // Right edge clipping, no wrap to column 0
        tick_req(10'd300, 10'd300, 10'd630, 10'd200);
        boundary("b2", 1'b1);
        probe("clip_630", 10'd630, 10'd200, 10'd0, 12'hF00);
        probe("clip_639", 10'd639, 10'd200, 10'd9, 12'hF00);
        probe("nowrap_0", 10'd0, 10'd200, 10'd0, 12'h123);
        probe("nowrap_21", 10'd21, 10'd200, 10'd0, 12'h123);

        // Second request overwrites pending
        tick_req(10'd300, 10'd300, 10'd10, 10'd10);
        tick_req(10'd300, 10'd301, 10'd20, 10'd20);
        boundary("b3", 1'b1);
        probe("ovr_new", 10'd20, 10'd20, 10'd0, 12'hF00);
        probe("ovr_old", 10'd15, 10'd15, 10'd0, 12'h123);
        boundary("b3_single", 1'b0);
        probe("ovr_keep", 10'd20, 10'd20, 10'd0, 12'hF00);

        // Request coincident with boundary while pending
        tick_req(10'd300, 10'd300, 10'd40, 10'd40);
        tick_req(10'd0, 10'd480, 10'd60, 10'd60);
        check("coin_ack", 32'(pos_ack), 32'd1);
        idle();
        probe("coin_old", 10'd40, 10'd40, 10'd0, 12'hF00);
        boundary("b4", 1'b1);
        probe("coin_new", 10'd60, 10'd60, 10'd0, 12'hF00);
        probe("coin_gone", 10'd40, 10'd40, 10'd0, 12'h123);

        // Request coincident with boundary while nothing pending
        tick_req(10'd0, 10'd480, 10'd80, 10'd80);
        check("coin0_ack", 32'(pos_ack), 32'd0);
        idle();
        probe("coin0_hold", 10'd60, 10'd60, 10'd0, 12'hF00);
        boundary("b5", 1'b1);
        probe("coin0_new", 10'd80, 10'd80, 10'd0, 12'hF00);

        // Asynchronous reset mid-line with a pending request
        tick_req(10'd300, 10'd300, 10'd300, 10'd300);
        tick(10'd400, 10'd100, 1'b1, 1'b0, 1'b0);
        tick(10'd401, 10'd100, 1'b1, 1'b0, 1'b0);
        tick(10'd402, 10'd100, 1'b1, 1'b0, 1'b0);
        check("pre_rst_rgb", 32'(rgb()), 32'h123);
        check("pre_rst_hsync", 32'(hsync_o), 32'd0);
        #5 rst = 1'b0;
        #1;
        check("arst_rgb", 32'(rgb()), 32'h000);
        check("arst_hsync", 32'(hsync_o), 32'd1);
        check("arst_vsync", 32'(vsync_o), 32'd1);
        @(posedge clk);
        #10 rst = 1'b1;
        boundary("post_rst", 1'b0);
        probe("post_rst_origin", 10'd5, 10'd3, 10'd101, 12'hF00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
